// File: rtl/mem_access_unit.sv
// Load/store sequencer between execute and datamem: one request in flight, one in-order response.
// Optional build macro MAU_ALIGN_CHECK_EN also faults requests with req_addr[7:0] != 0.
module mem_access_unit #(
  parameter int LOAD_WAIT  = 1,
  parameter int STORE_HOLD = 2,
  parameter int RD_W       = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_op,
  input  logic [23:0]     req_addr,
  input  logic [15:0]     req_wdata,
  input  logic [RD_W-1:0] req_rd,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_we,
  output logic [RD_W-1:0] rsp_rd,
  output logic [15:0]     rsp_data,
  output logic            rsp_err,
  output logic [1:0]      en_dm,
  output logic [23:0]     addr,
  output logic [15:0]     store_in,
  input  logic [15:0]     load_in
);
  localparam int CNT_MAX = (LOAD_WAIT > STORE_HOLD) ? LOAD_WAIT : STORE_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] LOAD_INIT  = CNT_W'(LOAD_WAIT - 1);
  localparam logic [CNT_W-1:0] STORE_INIT = CNT_W'(STORE_HOLD - 1);
  localparam logic [1:0] EN_IDLE = 2'b00, EN_ST = 2'b10, EN_LD = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]      en_dm_q, en_dm_d;
  logic [23:0]     addr_q, addr_d;
  logic [15:0]     store_in_q, store_in_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_we_q, rsp_we_d;
  logic [RD_W-1:0] rsp_rd_q, rsp_rd_d;
  logic [15:0]     rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic            fault;

`ifdef MAU_ALIGN_CHECK_EN
  assign fault = (req_addr[23:16] != 8'h00) || (req_addr[7:0] != 8'h00);
`else
  assign fault = (req_addr[23:16] != 8'h00);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      en_dm_q     <= EN_IDLE;
      addr_q      <= '0;
      store_in_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_rd_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      en_dm_q     <= en_dm_d;
      addr_q      <= addr_d;
      store_in_q  <= store_in_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_we_q    <= rsp_we_d;
      rsp_rd_q    <= rsp_rd_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    en_dm_d     = en_dm_q;
    addr_d      = addr_q;
    store_in_d  = store_in_q;
    rsp_valid_d = rsp_valid_q;
    rsp_we_d    = rsp_we_q;
    rsp_rd_d    = rsp_rd_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d     = req_addr;
          store_in_d = req_wdata;
          rsp_rd_d   = req_rd;
          rsp_we_d   = 1'b0;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          // Faulting requests never touch datamem; respond straight away.
          if (fault) begin
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = S_RESP;
          end else if (req_op) begin
            en_dm_d = EN_ST;
            cnt_d   = STORE_INIT;
            state_d = S_STORE;
          end else begin
            en_dm_d = EN_LD;
            cnt_d   = LOAD_INIT;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (cnt_q == '0) begin
          rsp_data_d  = load_in;
          rsp_we_d    = 1'b1;
          rsp_valid_d = 1'b1;
          en_dm_d     = EN_IDLE;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_STORE: begin
        if (cnt_q == '0) begin
          rsp_we_d    = 1'b0;
          rsp_data_d  = '0;
          rsp_valid_d = 1'b1;
          en_dm_d     = EN_IDLE;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_we    = rsp_we_q;
  assign rsp_rd    = rsp_rd_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign en_dm     = en_dm_q;
  assign addr      = addr_q;
  assign store_in  = store_in_q;
endmodule
